alu16_sequencer: RTL
====================

Name: alu16_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit ALU datapath twice (low byte, then high byte) to execute 16-bit operations: ADD HL,rr; INC rr; DEC rr; ADD SP,e8.
- Carries the byte carry/borrow between passes and assembles the 16-bit result and the ZNHC flag update.
- Sits between the decoder (which issues start/op) and the 8-bit ALU. The ALU stays combinational; this block owns its operand and carry-in inputs during a sequence.

Parameters:
- BYTE_W, 8, ALU datapath width; the result width is 2*BYTE_W.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  request a 16-bit operation; sampled only in IDLE.
- op  in  2  00=ADD16, 01=INC16, 10=DEC16, 11=ADDSP.
- opa  in  16  first operand (HL, rr or SP).
- opb  in  16  second operand; for ADDSP only opb[7:0] (signed e8) is used.
- flags_in  in  4  current {Z,N,H,C}.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; result and flags are valid in this cycle.
- result  out  16  assembled result, held until the next accepted start.
- flags_out  out  4  new {Z,N,H,C}.
- flags_we  out  1  asserted with done when the op writes flags.
- alu_a  out  8  ALU operand 1.
- alu_b  out  8  ALU operand 2.
- alu_cin  out  1  ALU carry-in (borrow-in when alu_sub=1).
- alu_sub  out  1  1 = ALU computes a-b-cin.
- alu_res  in  8  ALU result, combinational from alu_a/alu_b/alu_cin/alu_sub.
- alu_cout  in  1  carry out of bit 7 (borrow when subtracting).
- alu_hout  in  1  carry out of bit 3 (half-borrow when subtracting).

Behaviour:
- Reset (asynchronous, immediate), including mid-operation:
  - state=IDLE.
  - busy, done, flags_we, alu_a, alu_b, alu_cin, alu_sub, result, flags_out all 0.
  - Internal latches cleared.
- States: IDLE -> LO -> HI -> DONE -> IDLE. Unconditional advance except in IDLE.
- IDLE:
  - ALU outputs driven to 0.
  - start=1 latches op, opa, opb, flags_in and moves to LO.
  - start=0 stays in IDLE.
- Accept rules:
  - start is ignored while busy; there is no queueing.
  - The earliest next accept is the cycle after DONE.
- Byte operands:
  - ADD16: b_lo=opb[7:0], b_hi=opb[15:8], sub=0.
  - INC16: b_lo=01, b_hi=00, sub=0.
  - DEC16: b_lo=01, b_hi=00, sub=1.
  - ADDSP: b_lo=opb[7:0], b_hi = 8 copies of opb[7] (sign extension), sub=0.
- LO:
  - alu_a=opa[7:0], alu_b=b_lo, alu_cin=0.
  - Register res_lo=alu_res, c_lo=alu_cout, h_lo=alu_hout on exit.
- HI:
  - alu_a=opa[15:8], alu_b=b_hi, alu_cin=c_lo.
  - Register res_hi, c_hi, h_hi on exit.
- DONE:
  - result={res_hi,res_lo}; done=1; busy=1; ALU outputs 0.
- Flags:
  - ADD16: flags_out = {Z_in, 0, h_hi, c_hi}; flags_we=1.
  - ADDSP: flags_out = {0, 0, h_lo, c_lo}; flags_we=1. Flags come from the low byte only.
  - INC16/DEC16: flags_out=flags_in latched; flags_we=0.
- Latency: start accepted at edge N -> done high during cycle N+3. busy is high for exactly 3 cycles.
- Wrap-around: 16-bit modular arithmetic, no saturation.
  - FFFF+1=0000.
  - 0000-1=FFFF.
- ALU outputs are registered from state and latches. They must not depend combinationally on start/op.

Decomposition:
- Shared package/include alu16_pkg:
  - op encodings OP_ADD16, OP_INC16, OP_DEC16, OP_ADDSP;
  - state encodings S_IDLE, S_LO, S_HI, S_DONE;
  - flag bit indices F_Z=3, F_N=2, F_H=1, F_C=0.
- One sub-module is natural: alu16_opsel. It is combinational and maps (op, opb, phase) to {alu_b, alu_sub}.
- FSM, latches and flag assembly stay in the top.

Test Plan:
- ADD16, opa=0FFF, opb=0001, flags_in=1000 -> done at N+3, result=1000, flags_out=1010 (Z kept, H=1, C=0), flags_we=1.
- ADD16, opa=FFFF, opb=0001, flags_in=0000 -> result=0000, flags_out=0011 (Z not set), flags_we=1.
- ADDSP, opa=FFF8, opb=0008 -> result=0000, flags_out=0011. Then ADDSP with opa=0005, opb=00FE (-2) -> result=0003, flags_out=0011 (low byte 05+FE: H=1, C=1).
- DEC16, opa=0000, flags_in=0101 -> result=FFFF, alu_sub=1 in LO/HI, HI alu_cin=1, flags_we=0, flags_out=0101. INC16, opa=00FF -> result=0100.
- start held high continuously with varying op -> exactly one accept per 4 cycles. Operands presented while busy are ignored, and result reflects the latched values.
- RESET asserted during HI -> same-cycle busy=0 and all outputs 0, no done pulse. The first op after release completes normally in 3 cycles.

Source files
------------

// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared encodings for the 16-bit ALU sequencer
package alu16_pkg;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_INC16 = 2'b01,
        OP_DEC16 = 2'b10,
        OP_ADDSP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_H = 1;
    localparam int F_C = 0;

endpackage

// File: rtl/alu16_opsel.sv
// rtl/alu16_opsel.sv - per-byte ALU operand-2 and subtract select
// Ports: op (latched operation), opb (latched second operand),
//        phase_hi (0 = low byte pass, 1 = high byte pass),
//        alu_b / alu_sub (byte operand and subtract mode for this pass).
module alu16_opsel
    import alu16_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  op_e                 op,
    input  logic [2*BYTE_W-1:0] opb,
    input  logic                phase_hi,
    output logic [BYTE_W-1:0]   alu_b,
    output logic                alu_sub
);

    localparam logic [BYTE_W-1:0] ONE = {{(BYTE_W-1){1'b0}}, 1'b1};

    always_comb begin
        alu_b   = '0;
        alu_sub = 1'b0;
        case (op)
            OP_ADD16: alu_b = phase_hi ? opb[2*BYTE_W-1:BYTE_W] : opb[BYTE_W-1:0];
            OP_INC16: alu_b = phase_hi ? '0 : ONE;
            OP_DEC16: begin
                alu_b   = phase_hi ? '0 : ONE;
                alu_sub = 1'b1;
            end
            // e8 is sign-extended into the high byte.
            OP_ADDSP: alu_b = phase_hi ? {BYTE_W{opb[BYTE_W-1]}} : opb[BYTE_W-1:0];
            default: begin
                alu_b   = '0;
                alu_sub = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu16_sequencer.sv
// rtl/alu16_sequencer.sv - two-pass byte ALU sequencer for 16-bit ops
// Ports: CLK/RESET (async active-high); start/op/opa/opb/flags_in from decoder;
//        busy/done/result/flags_out/flags_we to the core;
//        alu_a/alu_b/alu_cin/alu_sub drive the 8-bit ALU, alu_res/alu_cout/alu_hout return.
module alu16_sequencer
    import alu16_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [2*BYTE_W-1:0] opa,
    input  logic [2*BYTE_W-1:0] opb,
    input  logic [3:0]          flags_in,
    output logic                busy,
    output logic                done,
    output logic [2*BYTE_W-1:0] result,
    output logic [3:0]          flags_out,
    output logic                flags_we,
    output logic [BYTE_W-1:0]   alu_a,
    output logic [BYTE_W-1:0]   alu_b,
    output logic                alu_cin,
    output logic                alu_sub,
    input  logic [BYTE_W-1:0]   alu_res,
    input  logic                alu_cout,
    input  logic                alu_hout
);

    state_e                state, state_nx;
    op_e                   op_q;
    logic [2*BYTE_W-1:0]   opa_q, opb_q;
    logic [3:0]            flags_q;
    logic [BYTE_W-1:0]     res_lo;
    logic                  c_lo, h_lo;
    logic [BYTE_W-1:0]     sel_b;
    logic                  sel_sub;

    // Operand selection only sees latched values, so the ALU inputs never
    // follow start/op combinationally.
    alu16_opsel #(.BYTE_W(BYTE_W)) u_opsel (
        .op       (op_q),
        .opb      (opb_q),
        .phase_hi (state == S_HI),
        .alu_b    (sel_b),
        .alu_sub  (sel_sub)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        flags_we = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_sub  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_LO;
            end
            S_LO: begin
                alu_a    = opa_q[BYTE_W-1:0];
                alu_b    = sel_b;
                alu_sub  = sel_sub;
                state_nx = S_HI;
            end
            S_HI: begin
                alu_a    = opa_q[2*BYTE_W-1:BYTE_W];
                alu_b    = sel_b;
                alu_sub  = sel_sub;
                alu_cin  = c_lo;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                flags_we = (op_q == OP_ADD16) || (op_q == OP_ADDSP);
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q      <= OP_ADD16;
            opa_q     <= '0;
            opb_q     <= '0;
            flags_q   <= '0;
            res_lo    <= '0;
            c_lo      <= 1'b0;
            h_lo      <= 1'b0;
            result    <= '0;
            flags_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        opa_q   <= opa;
                        opb_q   <= opb;
                        flags_q <= flags_in;
                    end
                end
                S_LO: begin
                    res_lo <= alu_res;
                    c_lo   <= alu_cout;
                    h_lo   <= alu_hout;
                end
                S_HI: begin
                    result <= {alu_res, res_lo};
                    case (op_q)
                        // ADD HL,rr keeps Z; H/C come from the high byte (bits 11/15).
                        OP_ADD16: begin
                            flags_out[F_Z] <= flags_q[F_Z];
                            flags_out[F_N] <= 1'b0;
                            flags_out[F_H] <= alu_hout;
                            flags_out[F_C] <= alu_cout;
                        end
                        // ADD SP,e8 takes H/C from the low byte (bits 3/7).
                        OP_ADDSP: begin
                            flags_out[F_Z] <= 1'b0;
                            flags_out[F_N] <= 1'b0;
                            flags_out[F_H] <= h_lo;
                            flags_out[F_C] <= c_lo;
                        end
                        default: flags_out <= flags_q;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
